// File: rtl/key_event_pkg.sv
// Shared constants for the key event scheduler: event type codes and the
// layout of one event word, which is {key index, type} with the type in bit 0.
package key_event_pkg;

  localparam logic EVT_SHORT    = 1'b0;
  localparam logic EVT_LONG     = 1'b1;
  localparam int   EVT_TYPE_BIT = 0;

  // Width of a key index. Never below 1 bit, so a two-key build still has an index.
  function automatic int key_idx_w(input int num_keys);
    return (num_keys <= 2) ? 1 : $clog2(num_keys);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce, short/long press classification
// and a single-entry pending slot that the top-level arbiter drains.
module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 300000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic key_in,
  input  logic grant,
  output logic key_held,
  output logic pend_valid,
  output logic pend_type,
  output logic drop
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  logic              sync1, sync2, stable, long_done;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept, rise, fall, raise_long, raise_short, raise, raise_type;

  always_comb begin
    accept      = enable && (sync2 != stable) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    rise        = accept && sync2;
    fall        = accept && !sync2;
    raise_long  = enable && stable && !long_done && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
    // A release landing on the same cycle as the long threshold still counts as long.
    raise_short = fall && !long_done && !raise_long;
    raise       = raise_long || raise_short;
    raise_type  = raise_long ? EVT_LONG : EVT_SHORT;
    drop        = raise && pend_valid;
  end

  assign key_held = stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable     <= 1'b0;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      pend_valid <= 1'b0;
      pend_type  <= EVT_SHORT;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      if (!enable) begin
        stable     <= 1'b0;
        db_cnt     <= '0;
        hold_cnt   <= '0;
        long_done  <= 1'b0;
        pend_valid <= 1'b0;
        pend_type  <= EVT_SHORT;
      end else begin
        if (sync2 == stable) begin
          db_cnt <= '0;
        end else if (accept) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end

        if (rise) begin
          hold_cnt  <= '0;
          long_done <= 1'b0;
        end else if (stable) begin
          if (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (raise_long) long_done <= 1'b1;
        end

        // An occupied slot always rejects a new event, even when granted this cycle.
        if (raise && !pend_valid) begin
          pend_valid <= 1'b1;
          pend_type  <= raise_type;
        end else if (grant) begin
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key front end: per-key channels feed a round-robin arbiter that
// writes one event per cycle into a small FIFO read by the consumer.
module key_event_scheduler
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS          = 5,
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 300000000,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_KEYS-1:0]           key_in,
  output logic [NUM_KEYS-1:0]           key_held,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [key_idx_w(NUM_KEYS)-1:0] evt_key,
  output logic                          evt_long,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int KW = key_idx_w(NUM_KEYS);
  localparam int EW = KW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_KEYS-1:0] pend_valid, pend_type, drop, grant;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .key_in    (key_in[g]),
      .grant     (grant[g]),
      .key_held  (key_held[g]),
      .pend_valid(pend_valid[g]),
      .pend_type (pend_type[g]),
      .drop      (drop[g])
    );
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [KW-1:0] rr_ptr, gnt_idx, cand_idx;
  logic          gnt_found, full, push, pop;
  logic [EW-1:0] head;

  // Handshake: an event transfers on a rising clk edge where evt_valid && evt_ready;
  // while evt_valid=1 and evt_ready=0 the head (evt_key, evt_long) holds still.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign head      = mem[rd_ptr];
  assign evt_key   = head[EW-1:EVT_TYPE_BIT+1];
  assign evt_long  = head[EVT_TYPE_BIT];

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_KEYS; i++) begin
      cand_idx = KW'((int'(rr_ptr) + i) % NUM_KEYS);
      if (!gnt_found && pend_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // A full FIFO still accepts a grant when the head leaves on the same edge.
  assign push = gnt_found && enable && (!full || pop);

  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_KEYS; k++) grant[k] = push && (gnt_idx == KW'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_ptr   <= KW'(NUM_KEYS - 1);
      overflow <= 1'b0;
      for (int d = 0; d < FIFO_DEPTH; d++) mem[d] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {gnt_idx, pend_type[gnt_idx]};
        wr_ptr      <= wr_ptr + PW'(1);
        rr_ptr      <= gnt_idx;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (|drop) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
